// File: rtl/window_3x3_gen.sv
// window_3x3_gen: 3x3 sliding window from the live pixel plus two line-delayed taps; optional WINDOW_3X3_GEN_STATS_EN adds frame/error counters.
// Latency: 1 cycle from the completing pixel beat to out_valid/out_window/out_row/out_col/out_eof.
// Backpressure: none; in_valid must stay high for a whole frame, a gap is a stream break held on out_err until the next sof.
module window_3x3_gen #(
    parameter int PIXEL_DEPTH = 8,
    parameter int WIDTH       = 8,
    parameter int HEIGHT      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic [PIXEL_DEPTH-1:0]     in_pixel,
    input  logic [PIXEL_DEPTH-1:0]     tap1_pixel,
    input  logic [PIXEL_DEPTH-1:0]     tap2_pixel,
    output logic [9*PIXEL_DEPTH-1:0]   out_window,
    output logic                       out_valid,
    output logic [$clog2(HEIGHT)-1:0]  out_row,
    output logic [$clog2(WIDTH)-1:0]   out_col,
    output logic                       out_eof,
    output logic                       out_err
`ifdef WINDOW_3X3_GEN_STATS_EN
    ,
    output logic [15:0]                out_frame_cnt,
    output logic [15:0]                out_err_cnt
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ERR = 2'd2} state_t;

    state_t state_q, state_d;
    logic [CW-1:0] col_q, col_d, beat_col;
    logic [RW-1:0] row_q, row_d, beat_row;
    // Row index 0 is the top (oldest line); column index 0 is the oldest column.
    logic [2:0][1:0][PIXEL_DEPTH-1:0] hist_q, hist_d;
    logic [2:0][PIXEL_DEPTH-1:0]      new_col;
    logic [9*PIXEL_DEPTH-1:0]         out_window_q, out_window_d;
    logic                             out_valid_q, out_valid_d;
    logic [RW-1:0]                    out_row_q, out_row_d;
    logic [CW-1:0]                    out_col_q, out_col_d;
    logic                             out_eof_q, out_eof_d;
    logic                             out_err_q, out_err_d;
    logic                             acc, beat_last, win_vld, brk;
`ifdef WINDOW_3X3_GEN_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
`endif

    // A sof beat always lands at (0,0), so it can never be the final beat of a frame.
    always_comb begin : beat_decode
        new_col   = {in_pixel, tap1_pixel, tap2_pixel};
        acc       = in_valid && (in_sof || state_q == RUN);
        brk       = (state_q == RUN) && !in_valid;
        beat_row  = in_sof ? '0 : row_q;
        beat_col  = in_sof ? '0 : col_q;
        beat_last = (beat_row == ROW_LAST) && (beat_col == COL_LAST);
        win_vld   = acc && (beat_row >= ROW_TWO) && (beat_col >= COL_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            hist_q       <= '0;
            out_window_q <= '0;
            out_valid_q  <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            out_eof_q    <= 1'b0;
            out_err_q    <= 1'b0;
`ifdef WINDOW_3X3_GEN_STATS_EN
            frame_cnt_q  <= '0;
            err_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            hist_q       <= hist_d;
            out_window_q <= out_window_d;
            out_valid_q  <= out_valid_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            out_eof_q    <= out_eof_d;
            out_err_q    <= out_err_d;
`ifdef WINDOW_3X3_GEN_STATS_EN
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
`endif
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE, ERR: if (in_valid && in_sof) state_d = RUN;
            RUN: begin
                if (!in_valid)      state_d = ERR;
                else if (beat_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : outputs
        col_d        = col_q;
        row_d        = row_q;
        hist_d       = hist_q;
        out_window_d = out_window_q;
        out_valid_d  = win_vld;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        out_eof_d    = win_vld && beat_last;
        out_err_d    = out_err_q;
        if (in_valid) begin
            for (int i = 0; i < 3; i++) begin
                hist_d[i][0] = hist_q[i][1];
                hist_d[i][1] = new_col[i];
            end
        end
        if (acc) begin
            if (beat_col == COL_LAST) begin
                col_d = '0;
                row_d = (beat_row == ROW_LAST) ? '0 : beat_row + ROW_ONE;
            end else begin
                col_d = beat_col + COL_ONE;
                row_d = beat_row;
            end
        end
        if (win_vld) begin
            for (int i = 0; i < 3; i++) begin
                out_window_d[(3*i)*PIXEL_DEPTH +: PIXEL_DEPTH]   = hist_q[i][0];
                out_window_d[(3*i+1)*PIXEL_DEPTH +: PIXEL_DEPTH] = hist_q[i][1];
                out_window_d[(3*i+2)*PIXEL_DEPTH +: PIXEL_DEPTH] = new_col[i];
            end
            out_row_d = beat_row - ROW_ONE;
            out_col_d = beat_col - COL_ONE;
        end
        if (brk)                        out_err_d = 1'b1;
        else if (in_valid && in_sof)    out_err_d = 1'b0;
`ifdef WINDOW_3X3_GEN_STATS_EN
        frame_cnt_d = (out_eof_d && frame_cnt_q != 16'hFFFF) ? frame_cnt_q + 16'd1 : frame_cnt_q;
        err_cnt_d   = (brk && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
`endif
    end

    assign out_window = out_window_q;
    assign out_valid  = out_valid_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign out_eof    = out_eof_q;
    assign out_err    = out_err_q;
`ifdef WINDOW_3X3_GEN_STATS_EN
    assign out_frame_cnt = frame_cnt_q;
    assign out_err_cnt   = err_cnt_q;
`endif

endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Downstream neighbour of the line-buffer stage: forms a 3x3 sliding pixel window from the live pixel plus two line-delayed taps.
- The taps come from linebuffer instances with NUM_LINES=1 and NUM_LINES=2.
- Tracks row/column position, emits only fully-interior windows with a valid strobe, flags end of frame, and detects stream breaks that would misalign the free-running line buffers.
- Feeds the downstream 3x3 filter/feature stages.

Parameters:
- PIXEL_DEPTH, 8, bits per pixel.
- WIDTH, 8, pixels per line; must equal the WIDTH of the feeding line buffers; >= 3.
- HEIGHT, 8, lines per frame; >= 3.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  pixel beat qualifier; must stay high for every beat of a frame.
- in_sof  input  1  start of frame; valid only with in_valid, marks pixel (0,0).
- in_pixel  input  PIXEL_DEPTH  current pixel, row r.
- tap1_pixel  input  PIXEL_DEPTH  row r-1 pixel, same column (single-line delay).
- tap2_pixel  input  PIXEL_DEPTH  row r-2 pixel, same column (double-line delay).
- out_window  output  9*PIXEL_DEPTH  window packed row-major. [PIXEL_DEPTH-1:0] is top-left (oldest row, oldest column); the top slice is bottom-right (newest pixel).
- out_valid  output  1  out_window holds a complete interior window.
- out_row  output  $clog2(HEIGHT)  row of window centre.
- out_col  output  $clog2(WIDTH)  column of window centre.
- out_eof  output  1  one-cycle pulse with the last window of a frame.
- out_err  output  1  sticky stream-break flag.

Behaviour:
- Reset (async assert, sync deassert):
  - all outputs 0, window registers 0, counters 0, FSM IDLE.
  - Reset mid-frame abandons the frame; no out_eof.
- FSM states:
  - IDLE: wait for in_valid&in_sof; go to RUN with col=0, row=0 for that beat.
  - RUN: each in_valid beat advances col; at col=WIDTH-1, col wraps to 0 and row increments. On the beat at (HEIGHT-1, WIDTH-1) go to IDLE.
  - RUN with in_valid=0: go to ERR, set out_err. Counters and window hold.
  - ERR: wait for in_valid&in_sof; then clear out_err, restart at (0,0), go to RUN.
  - in_sof&in_valid in RUN at a position other than (0,0): treat as a new frame. Restart at (0,0), no error, no out_eof for the abandoned frame.
- Window shift: on every in_valid beat, each row's 3-entry shift register shifts one column left.
  - Newest column loads tap2_pixel (top row), tap1_pixel (middle), in_pixel (bottom).
  - Shifting continues across line wrap. Stale columns are masked by the valid logic, not cleared.
- Valid rule: the beat at position (r,c) with r>=2 and c>=2 produces, on the next clk edge:
  - out_valid=1
  - out_window updated with that beat's columns
  - out_row=r-1, out_col=c-1
- Otherwise out_valid=0 on that edge. out_window/out_row/out_col hold their last values while out_valid=0.
- Latency: 1 cycle from the completing pixel beat to out_valid. Windows per frame = (HEIGHT-2)*(WIDTH-2).
- out_eof=1 on the same edge as the window for beat (HEIGHT-1, WIDTH-1); 0 otherwise.
- Simultaneous sof and final beat: the sof wins. No eof, new frame starts.
- Counter widths: $clog2 of each dimension. The wrap compare is against WIDTH-1/HEIGHT-1 exactly; never rely on natural overflow.

Optional Feature:
- Macro WINDOW_3X3_GEN_STATS_EN.
- Defined:
  - adds output out_frame_cnt (16 bits): count of frames completed with out_eof. Increments on the out_eof edge, saturates at 16'hFFFF, reset to 0.
  - adds output out_err_cnt (16 bits): count of RUN->ERR transitions, saturating, reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- WIDTH=8, HEIGHT=6, continuous frame, pixel value = row*16+col, taps from two linebuffer instances -> exactly 24 out_valid pulses.
  - First window: out_row=1, out_col=1, out_window = {0x22,0x21,0x20,0x12,0x11,0x10,0x02,0x01,0x00}.
  - out_eof only with the window out_row=4, out_col=6.
- Same frame: check the first pixel beat of row 2 (col 0) and the beat at col 1 -> out_valid=0 on both. No window spans the line wrap.
- in_valid dropped for 1 cycle at (3,4) -> out_err=1 the next cycle and no further out_valid. Next in_sof clears out_err and the 24-window count restarts.
- in_sof reasserted at (2,5) -> counters restart at (0,0). No out_eof for the aborted frame; the following full frame yields 24 windows.
- rst_n asserted asynchronously mid-RUN (between clk edges) -> all outputs 0 immediately. After release, a new frame behaves as in the first scenario.
- With WINDOW_3X3_GEN_STATS_EN, run 3 good frames and 1 broken frame -> out_frame_cnt=3, out_err_cnt=1.
